// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register sentinel
// and the fetch controller state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_HOLD,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_len_dec.sv
// Instruction length and validity decode from the first instruction byte.
// Optional FETCH_CTRL_IFUN_CHECK_EN also rejects undefined ifun values.
module instr_len_dec
    import y86_pkg::*;
(
    input  logic [7:0] byte0,
    output logic [3:0] len,
    output logic       invalid
);

    logic [3:0] icode;
    logic [3:0] ifun;

    assign icode = byte0[7:4];
    assign ifun  = byte0[3:0];

`ifdef FETCH_CTRL_IFUN_CHECK_EN
    logic ifun_bad;

    always_comb begin
        case (icode)
            IOPQ:          ifun_bad = (ifun > 4'd3);
            IRRMOVQ, IJXX: ifun_bad = (ifun > 4'd6);
            default:       ifun_bad = (ifun != 4'd0);
        endcase
    end
`else
    logic unused_ifun;
    logic ifun_bad;

    assign unused_ifun = ^ifun;
    assign ifun_bad    = 1'b0;
`endif

    always_comb begin
        len     = 4'd1;
        invalid = 1'b0;
        case (icode)
            IHALT, INOP, IRET:             len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  len = 4'd2;
            IJXX, ICALL:                   len = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:     len = 4'd10;
            default:                       invalid = 1'b1;
        endcase
        // invalid encodings are treated as one-byte instructions
        if (ifun_bad) begin
            invalid = 1'b1;
        end
        if (invalid) begin
            len = 4'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Y86-64 byte-serial instruction fetch: reads one byte per cycle from a
// synchronous imem and presents decoded fields with a valid/ready handshake.
module fetch_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int PC_W      = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    input  logic [7:0]      mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      rA,
    output logic [3:0]      rB,
    output logic [63:0]     valC,
    output logic [63:0]     valP,
    output logic [1:0]      stat,
    output logic            busy
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      k_q, k_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      last_q, last_d;
    logic [3:0]      icode_q, icode_d, ifun_q, ifun_d;
    logic [3:0]      ra_q, ra_d, rb_q, rb_d;
    logic [63:0]     valc_q, valc_d, valp_q, valp_d;
    logic [1:0]      stat_q, stat_d;

    logic [3:0]  dec_len;
    logic        dec_inv;
    logic [63:0] pc64, avail, dec_end;
    logic [3:0]  first_last, cur_last;
    logic [1:0]  first_stat;
    logic [2:0]  bidx;
    logic        start_fetch;

    instr_len_dec u_dec (
        .byte0   (mem_rdata),
        .len     (dec_len),
        .invalid (dec_inv)
    );

    assign pc64    = 64'(pc_q);
    assign avail   = (pc64 < 64'(MEM_BYTES)) ? 64'(MEM_BYTES) - pc64 : '0;
    assign dec_end = pc64 + 64'(dec_len);

    // An instruction running past the end of memory stops at the last in-range byte.
    always_comb begin
        first_last = dec_len - 4'd1;
        first_stat = STAT_AOK;
        if (dec_end > 64'(MEM_BYTES)) begin
            first_stat = STAT_ADR;
            first_last = (avail == '0) ? 4'd0 : 4'(avail - 64'd1);
        end else if (dec_inv) begin
            first_stat = STAT_INS;
        end else if (mem_rdata[7:4] == IHALT) begin
            first_stat = STAT_HLT;
        end
    end

    assign cur_last = (k_q == 4'd0) ? first_last : last_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        k_d         = k_q;
        len_d       = len_q;
        last_d      = last_q;
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        valc_d      = valc_q;
        valp_d      = valp_q;
        stat_d      = stat_q;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        start_fetch = 1'b0;
        bidx        = (len_q == 4'd10) ? 3'(k_q - 4'd2) : 3'(k_q - 4'd1);

        case (state_q)
            S_IDLE: begin
                start_fetch = pc_load;
            end
            S_RD: begin
                if (k_q < cur_last) begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_q + PC_W'(k_q) + PC_W'(1);
                end
                if (k_q == 4'd0) begin
                    icode_d = mem_rdata[7:4];
                    ifun_d  = mem_rdata[3:0];
                    len_d   = dec_len;
                    last_d  = first_last;
                    stat_d  = first_stat;
                    valp_d  = dec_end;
                end else if (k_q == 4'd1 && (len_q == 4'd2 || len_q == 4'd10)) begin
                    ra_d = mem_rdata[7:4];
                    rb_d = mem_rdata[3:0];
                end else if (len_q == 4'd9 || len_q == 4'd10) begin
                    valc_d[{bidx, 3'b000} +: 8] = mem_rdata;
                end
                if (k_q == cur_last) begin
                    state_d = S_HOLD;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (stat_q == STAT_AOK) begin
                        state_d     = S_IDLE;
                        start_fetch = pc_load;
                    end else begin
                        state_d = S_HALT;
                    end
                end
            end
            default: ;
        endcase

        if (start_fetch) begin
            state_d  = S_RD;
            pc_d     = pc_in;
            k_d      = 4'd0;
            icode_d  = 4'd0;
            ifun_d   = 4'd0;
            ra_d     = RNONE;
            rb_d     = RNONE;
            valc_d   = '0;
            valp_d   = '0;
            stat_d   = STAT_AOK;
            mem_addr = pc_in;
            mem_rd   = (64'(pc_in) < 64'(MEM_BYTES));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            k_q     <= '0;
            len_q   <= '0;
            last_q  <= '0;
            icode_q <= '0;
            ifun_q  <= '0;
            ra_q    <= RNONE;
            rb_q    <= RNONE;
            valc_q  <= '0;
            valp_q  <= '0;
            stat_q  <= STAT_AOK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            len_q   <= len_d;
            last_q  <= last_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            stat_q  <= stat_d;
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_RD) || (state_q == S_HOLD);
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign stat      = stat_q;

endmodule
